// File: rtl/data_memory_responder.sv
// Fixed-latency data memory responder for the data cache miss interface.
// Optional macro DMEM_PERF_EN adds completed read/write counters on RdCount/WrCount.
module data_memory_responder #(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 4
) (
    input  logic        CLK,
    input  logic        Reset_n,
    input  logic        Req,
    input  logic        MemWrite2Memory,
    input  logic [31:0] MissAddr,
    input  logic [31:0] Data2Memory,
    output logic [31:0] ReadData,
    output logic        memory_ready,
    output logic        Busy,
    output logic [31:0] RdCount,
    output logic [31:0] WrCount
);

    localparam int          AW       = $clog2(DEPTH);
    localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        READY = 2'd2,
        COOL  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [31:0]     rdata_q, rdata_d;
    logic            ready_q, ready_d;
    logic            busy_q, busy_d;
    logic [AW-1:0]   idx_q, idx_d;
    logic            wr_q, wr_d;
    logic [31:0]     wdata_q, wdata_d;
    logic            commit;

    logic [31:0]     mem [DEPTH];

    // Address bits outside the word index are deliberately dropped.
    logic            unused_addr;
    assign unused_addr = ^{MissAddr[31:AW+2], MissAddr[1:0]};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        idx_d   = idx_q;
        wr_d    = wr_q;
        wdata_d = wdata_q;
        commit  = 1'b0;
        case (state_q)
            IDLE: begin
                if (Req) begin
                    state_d = BUSY;
                    cnt_d   = CNT_INIT;
                    idx_d   = MissAddr[AW+1:2];
                    wr_d    = MemWrite2Memory;
                    wdata_d = Data2Memory;
                end
            end
            BUSY: begin
                if (cnt_q == 4'd0) begin
                    state_d = READY;
                    commit  = 1'b1;
                    if (!wr_q) begin
                        rdata_d = mem[idx_q];
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            READY:   state_d = COOL;
            COOL:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        ready_d = (state_d == READY);
        busy_d  = (state_d == BUSY);
    end

    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            rdata_q <= 32'd0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
        end
    end

    // Request payload only changes on acceptance, so it needs no reset.
    always_ff @(posedge CLK) begin
        idx_q   <= idx_d;
        wr_q    <= wr_d;
        wdata_q <= wdata_d;
    end

    // commit is derived from state_q, which reset forces to IDLE, so a
    // write caught by reset never reaches the array.
    always_ff @(posedge CLK) begin
        if (commit && wr_q) begin
            mem[idx_q] <= wdata_q;
        end
    end

    assign ReadData     = rdata_q;
    assign memory_ready = ready_q;
    assign Busy         = busy_q;

`ifdef DMEM_PERF_EN
    logic [31:0] rd_cnt_q, rd_cnt_d;
    logic [31:0] wr_cnt_q, wr_cnt_d;

    always_comb begin
        rd_cnt_d = rd_cnt_q;
        wr_cnt_d = wr_cnt_q;
        if (commit) begin
            if (wr_q) begin
                wr_cnt_d = wr_cnt_q + 32'd1;
            end else begin
                rd_cnt_d = rd_cnt_q + 32'd1;
            end
        end
    end

    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            rd_cnt_q <= 32'd0;
            wr_cnt_q <= 32'd0;
        end else begin
            rd_cnt_q <= rd_cnt_d;
            wr_cnt_q <= wr_cnt_d;
        end
    end

    assign RdCount = rd_cnt_q;
    assign WrCount = wr_cnt_q;
`else
    assign RdCount = 32'd0;
    assign WrCount = 32'd0;
`endif

endmodule

// File: tb/tb_data_memory_responder.sv
// Scoreboard bench for data_memory_responder: driver queues expected completions,
// a negedge monitor pops and checks them whenever memory_ready is seen.
module tb_data_memory_responder;

    localparam int LAT   = 4;
    localparam int DEPTH = 1024;

    logic        CLK = 1'b0;
    logic        Reset_n;
    logic        Req;
    logic        MemWrite2Memory;
    logic [31:0] MissAddr;
    logic [31:0] Data2Memory;
    logic [31:0] ReadData;
    logic        memory_ready;
    logic        Busy;
    logic [31:0] RdCount;
    logic [31:0] WrCount;

    data_memory_responder #(.DEPTH(DEPTH), .LATENCY(LAT)) dut (
        .CLK             (CLK),
        .Reset_n         (Reset_n),
        .Req             (Req),
        .MemWrite2Memory (MemWrite2Memory),
        .MissAddr        (MissAddr),
        .Data2Memory     (Data2Memory),
        .ReadData        (ReadData),
        .memory_ready    (memory_ready),
        .Busy            (Busy),
        .RdCount         (RdCount),
        .WrCount         (WrCount)
    );

    always #5 CLK = ~CLK;

    int unsigned cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        int unsigned cyc;
        logic        rd;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
        end
    endtask

    // Monitor: every completion must match the head of the scoreboard.
    always @(negedge CLK) begin
        if (Reset_n === 1'b1 && memory_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ready: got pulse at cycle %0d expected none", cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check32("ready_cycle", cyc, e.cyc);
                if (e.rd) check32("read_data", ReadData, e.data);
            end
        end
    end

    task automatic wait_drain();
        for (int i = 0; i < 60 && exp_q.size() != 0; i++) @(negedge CLK);
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
            exp_q.delete();
        end
        @(negedge CLK);
        @(negedge CLK);
    endtask

    task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [31:0] exp_rd);
        exp_t e;
        int unsigned acc;
        @(negedge CLK);
        Req = 1'b1;
        MemWrite2Memory = we;
        MissAddr = addr;
        Data2Memory = wd;
        @(posedge CLK);
        #1;
        acc = cyc;
        Req = 1'b0;
        MemWrite2Memory = 1'b0;
        MissAddr = 32'hFFFF_FFFF;
        Data2Memory = 32'h5A5A_5A5A;
        check32("busy_after_accept", {31'd0, Busy}, 32'd1);
        e.cyc = acc + LAT;
        e.rd = !we;
        e.data = exp_rd;
        exp_q.push_back(e);
        wait_drain();
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int unsigned k0;
        exp_t e;
        Reset_n = 1'b0;
        Req = 1'b0;
        MemWrite2Memory = 1'b0;
        MissAddr = 32'd0;
        Data2Memory = 32'd0;
        repeat (3) @(posedge CLK);
        #1;
        check32("rst_ready", {31'd0, memory_ready}, 32'd0);
        check32("rst_busy", {31'd0, Busy}, 32'd0);
        check32("rst_rdata", ReadData, 32'd0);
        check32("rst_rdcount", RdCount, 32'd0);
        check32("rst_wrcount", WrCount, 32'd0);
        @(negedge CLK);
        Reset_n = 1'b1;

        // Write then read back, then index wrap.
        issue(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'd0);
        issue(1'b0, 32'h0000_0010, 32'd0, 32'hDEAD_BEEF);
        issue(1'b1, 32'h0000_1004, 32'h1234_5678, 32'd0);
        issue(1'b0, 32'h0000_0004, 32'd0, 32'h1234_5678);
        check32("rdata_hold_idle", ReadData, 32'h1234_5678);

        // Held Req: acceptances LAT+3 apart, none during COOL.
        @(negedge CLK);
        Req = 1'b1;
        MemWrite2Memory = 1'b0;
        MissAddr = 32'h0000_0013;
        @(posedge CLK);
        #1;
        k0 = cyc;
        for (int n = 0; n < 3; n++) begin
            e.cyc = k0 + LAT + n * (LAT + 3);
            e.rd = 1'b1;
            e.data = 32'hDEAD_BEEF;
            exp_q.push_back(e);
        end
        while (cyc < k0 + 2 * (LAT + 3) + 1) @(negedge CLK);
        Req = 1'b0;
        wait_drain();

        // Aborted write: reset during BUSY drops it.
        @(negedge CLK);
        Req = 1'b1;
        MemWrite2Memory = 1'b1;
        MissAddr = 32'h0000_0020;
        Data2Memory = 32'hAAAA_AAAA;
        @(posedge CLK);
        #1;
        Req = 1'b0;
        MemWrite2Memory = 1'b0;
        check32("abort_busy_before", {31'd0, Busy}, 32'd1);
        @(negedge CLK);
        @(negedge CLK);
        Reset_n = 1'b0;
        #1;
        check32("abort_busy_after", {31'd0, Busy}, 32'd0);
        check32("abort_ready_after", {31'd0, memory_ready}, 32'd0);
        check32("abort_rdata_cleared", ReadData, 32'd0);
        @(negedge CLK);
        Reset_n = 1'b1;
        repeat (LAT + 2) @(negedge CLK);

        issue(1'b0, 32'h0000_0020, 32'd0, 32'd0);
        issue(1'b1, 32'h0000_3FFC, 32'h0BAD_F00D, 32'd0);
        issue(1'b0, 32'h0000_0FFC, 32'd0, 32'h0BAD_F00D);
        issue(1'b1, 32'h0000_0000, 32'h0000_0001, 32'd0);
        check32("rdata_kept_over_write", ReadData, 32'h0BAD_F00D);
        issue(1'b0, 32'h8000_0002, 32'd0, 32'h0000_0001);

`ifdef DMEM_PERF_EN
        check32("rdcount", RdCount, 32'd3);
        check32("wrcount", WrCount, 32'd2);
`else
        check32("rdcount", RdCount, 32'd0);
        check32("wrcount", WrCount, 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/data_memory_responder.md
# data_memory_responder

Memory-side responder for the data cache miss interface. It accepts a cache request (refill read or write-through write), holds it for a fixed, parameterised latency, then completes it with a one-cycle `memory_ready` pulse. On reads it returns the word on `ReadData`; on writes it commits `Data2Memory` into an internal word array. It sits at the processor top level, opposite the core's `MissAddr` / `MemWrite2Memory` / `Data2Memory` / `ReadData` / `memory_ready` signals, and replaces a zero-latency data memory.

## Interface
Parameters:
- `DEPTH`, 1024: number of 32-bit words in the array; power of two.
- `LATENCY`, 4: cycles from request acceptance to `memory_ready`; legal range 1..15.

Ports:
- `CLK`  in  1  clock; all state updates on the rising edge.
- `Reset_n`  in  1  asynchronous, active-low reset.
- `Req`  in  1  request valid; the top level drives it from `!Hit`.
- `MemWrite2Memory`  in  1  1 = write request, 0 = read (refill) request.
- `MissAddr`  in  32  byte address; word index is `MissAddr[log2(DEPTH)+1:2]`.
- `Data2Memory`  in  32  write data.
- `ReadData`  out  32  read data; valid while `memory_ready` = 1.
- `memory_ready`  out  1  one-cycle completion pulse.
- `Busy`  out  1  high while a request is held (state BUSY).
- `RdCount`  out  32  completed reads (only meaningful with `DMEM_PERF_EN`).
- `WrCount`  out  32  completed writes (only meaningful with `DMEM_PERF_EN`).

## Operation
- There are four states: IDLE, BUSY, READY, COOL.
- **IDLE:** on a rising edge with `Req` = 1:
  - latch the address word index, `MemWrite2Memory` and `Data2Memory`;
  - load the latency counter with `LATENCY`-1;
  - go to BUSY.
  - With `Req` = 0, stay in IDLE.
- **BUSY:** the counter decrements each edge. Inputs are ignored, because the request is latched.
  - When the counter is 0, on the next edge go to READY.
  - In the same edge, a write commits the latched data to the array; a read loads `ReadData` from the array.
- **READY:** `memory_ready` = 1 for exactly this cycle. The next edge goes to COOL unconditionally.
- **COOL:** a single dead cycle that lets the cache consume the response and update `Hit`. The next edge goes to IDLE. `Req` is not sampled in this state.
- `ReadData` holds its last read value until the next read completes. Writes do not change `ReadData`.
- Address handling:
  - Upper address bits above the index are ignored, so accesses wrap modulo `DEPTH`.
  - `MissAddr[1:0]` is ignored.
- Array contents are not reset. Simulation initial contents are zero.
- Reset (`Reset_n` = 0, at any time, including mid-request):
  - state goes to IDLE; `memory_ready` = 0; `Busy` = 0; `ReadData` = 0; counter = 0; `RdCount` = 0; `WrCount` = 0;
  - an uncommitted write is dropped and the array is unmodified;
  - release is synchronous to the first rising edge with `Reset_n` = 1.

## Timing
- Request sampled at edge k. Then:
  - `Busy` = 1 from edge k to edge k+`LATENCY`-1;
  - write commit and `ReadData` load happen at edge k+`LATENCY`;
  - `memory_ready` = 1 during the cycle between edges k+`LATENCY` and k+`LATENCY`+1;
  - COOL lasts until edge k+`LATENCY`+2;
  - the earliest next acceptance is edge k+`LATENCY`+3.
- With `LATENCY` = 1: BUSY lasts one cycle and READY follows at edge k+1.
- Throughput is one request per `LATENCY`+3 cycles.
- A write followed by a read to the same address returns the new data, because the commit precedes the second acceptance.
- All outputs are registered. There are no combinational input-to-output paths.

## Configuration
- `DMEM_PERF_EN` defined:
  - `RdCount` increments at the READY-entry edge of each read;
  - `WrCount` increments at the READY-entry edge of each write;
  - both counters wrap at 2^32.
- `DMEM_PERF_EN` undefined: the counter logic is absent and `RdCount` / `WrCount` are tied to 0.

## Test plan
- **Reset:** hold `Reset_n` = 0 for 3 cycles. Expect `memory_ready` = 0, `Busy` = 0, `ReadData` = 0. Assert `Reset_n` mid-BUSY and expect an immediate return to IDLE.
- **Write then read, LATENCY = 4:**
  - write 0xDEADBEEF to 0x0000_0010 → `memory_ready` pulses exactly 4 cycles after acceptance;
  - read 0x0000_0010 → `ReadData` = 0xDEADBEEF during the `memory_ready` cycle;
  - accept-to-accept spacing = 7 cycles.
- **Wrap, DEPTH = 1024:** write 0x1234_5678 to 0x0000_1004, then read 0x0000_0004 → 0x1234_5678.
- **Held Req:** keep `Req` = 1 continuously with a constant read address. Expect `memory_ready` pulses exactly every `LATENCY`+3 cycles, and no acceptance during COOL.
- **Aborted write:** start a write of 0xAAAA_AAAA to 0x20, then pulse `Reset_n` low during BUSY. A later read of 0x20 returns the prior value, 0.
- **DMEM_PERF_EN:** perform 3 reads and 2 writes → `RdCount` = 3, `WrCount` = 2. Without the macro, both read 0.
